// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Round-robin front end that lets two requesters share one ALU. A single
// operation is outstanding at a time: it is accepted in IDLE, issued to the
// ALU with a one-cycle strobe, waited on (bounded by TIMEOUT cycles), then
// returned on a valid/ready response channel.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   req{0,1}_valid/ready     request handshake (ready is combinational)
//   req{0,1}_func/a/b        ALU function code and operands
//   alu_en                   registered one-cycle issue strobe
//   alu_func/a/b             registered operation presented to the ALU
//   alu_result, alu_done     ALU result and completion strobe
//   rsp_valid/ready          response handshake
//   rsp_id                   requester that owns the response
//   rsp_data, rsp_err        result, or zero with err=1 on timeout
//   busy                     high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DWIDTH  = 16,
    parameter int TIMEOUT = 8      // legal range 2..255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_func,
    input  logic [DWIDTH-1:0] req0_a,
    input  logic [DWIDTH-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_func,
    input  logic [DWIDTH-1:0] req1_a,
    input  logic [DWIDTH-1:0] req1_b,
    output logic              alu_en,
    output logic [2:0]        alu_func,
    output logic [DWIDTH-1:0] alu_a,
    output logic [DWIDTH-1:0] alu_b,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic              alu_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       prio;          // 1: req1 preferred when both are valid
    logic [7:0] wait_cnt;
    logic       grant0;
    logic       grant1;
    logic       timeout_hit;

    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || !prio)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // Done has priority over a coincident timeout.
                if (alu_done || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // No accept is ever signalled while reset is held.
        if (rst) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers; all are cleared on reset so an abandoned
    // transaction leaves nothing visible on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio      <= 1'b0;
            wait_cnt  <= 8'd0;
            alu_en    <= 1'b0;
            alu_func  <= 3'd0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // Grants only occur in IDLE, so the strobe lands exactly in ISSUE.
            alu_en <= grant0 || grant1;

            if (grant0 || grant1) begin
                alu_func <= grant1 ? req1_func : req0_func;
                alu_a    <= grant1 ? req1_a    : req0_a;
                alu_b    <= grant1 ? req1_b    : req0_b;
                rsp_id   <= grant1;
                // Hand priority to the requester that lost this grant.
                prio     <= grant0;
            end

            case (state)
                ISSUE: wait_cnt <= 8'd0;
                WAIT: begin
                    if (alu_done) begin
                        rsp_data  <= alu_result;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A one-cycle ALU model answers issued
// operations; it can be muted and a done strobe can be injected by hand.
// Table rows exercise arbitration and ALU functions; hand-written sequences
// cover contention, backpressure, timeout, reset mid-operation and stray
// done pulses. Expected responses travel through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int DW = 16;
    localparam int TO = 8;

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_AND = 3'd2;
    localparam logic [2:0] F_OR  = 3'd3;
    localparam logic [2:0] F_XOR = 3'd4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_func, req1_func;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          alu_en;
    logic [2:0]    alu_func;
    logic [DW-1:0] alu_a, alu_b;
    logic [DW-1:0] alu_result;
    logic          alu_done;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [DW-1:0] rsp_data;

    always #5 clk = ~clk;

    alu_arbiter #(.DWIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
        .alu_en(alu_en), .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    // ---------------- ALU model ----------------
    function automatic logic [DW-1:0] alu_model(input logic [2:0] f,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (f)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_XOR:   return a ^ b;
            default: return a;
        endcase
    endfunction

    logic          alu_auto;
    logic          done_inj;
    logic [DW-1:0] inj_result;
    logic          alu_pipe = 1'b0;
    logic [DW-1:0] res_pipe = '0;

    always @(posedge clk) begin
        alu_pipe <= alu_en & alu_auto;
        res_pipe <= alu_model(alu_func, alu_a, alu_b);
    end

    assign alu_done   = alu_pipe | done_inj;
    assign alu_result = done_inj ? inj_result : res_pipe;

    // ---------------- checking infrastructure ----------------
    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t sb[$];

    typedef struct {
        logic          v0;
        logic          v1;
        logic [2:0]    f0;
        logic [DW-1:0] a0;
        logic [DW-1:0] b0;
        logic [2:0]    f1;
        logic [DW-1:0] a1;
        logic [DW-1:0] b1;
        logic          exp_id;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while (busy && w < 40) begin
            tick();
            w++;
        end
        check({tag, " idle before start"}, 32'(busy), 0);
    endtask

    task automatic wait_rsp(input int budget, output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < budget) begin
            tick();
            cycles++;
        end
    endtask

    task automatic compare_rsp(input string tag);
        rsp_t e;
        check({tag, " rsp_valid"}, 32'(rsp_valid), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, " rsp_id"},   32'(rsp_id),   32'(e.id));
            check({tag, " rsp_data"}, 32'(rsp_data), 32'(e.data));
            check({tag, " rsp_err"},  32'(rsp_err),  32'(e.err));
        end else begin
            n_fail++;
            $display("FAIL %s scoreboard: got response, expected none queued", tag);
        end
    endtask

    task automatic drive_req(input logic v0, input logic [2:0] f0,
                             input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                             input logic v1, input logic [2:0] f1,
                             input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        req0_valid = v0; req0_func = f0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_func = f1; req1_a = a1; req1_b = b1;
        #1;
    endtask

    // One table row with nominal latency and rsp_ready held high.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        wait_idle(tag);
        drive_req(v.v0, v.f0, v.a0, v.b0, v.v1, v.f1, v.a1, v.b1);
        check({tag, " ready0"}, 32'(req0_ready), 32'(v.exp_id == 1'b0));
        check({tag, " ready1"}, 32'(req1_ready), 32'(v.exp_id == 1'b1));
        sb.push_back('{id: v.exp_id, data: v.exp_data, err: 1'b0});
        tick();  // accept edge -> ISSUE
        check({tag, " ready0 busy"}, 32'(req0_ready), 0);
        check({tag, " ready1 busy"}, 32'(req1_ready), 0);
        check({tag, " alu_en"},   32'(alu_en), 1);
        check({tag, " alu_func"}, 32'(alu_func), 32'(v.exp_id ? v.f1 : v.f0));
        check({tag, " alu_a"},    32'(alu_a),    32'(v.exp_id ? v.a1 : v.a0));
        check({tag, " alu_b"},    32'(alu_b),    32'(v.exp_id ? v.b1 : v.b0));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();  // WAIT
        check({tag, " alu_en one cycle"}, 32'(alu_en), 0);
        check({tag, " rsp_valid early"},  32'(rsp_valid), 0);
        tick();  // RESP, three cycles after accept
        compare_rsp(tag);
        tick();
        check({tag, " rsp_valid after hs"}, 32'(rsp_valid), 0);
        check({tag, " busy after hs"},      32'(busy), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        rst = 1'b1;
        rsp_ready = 1'b1;
        alu_auto = 1'b1;
        done_inj = 1'b0;
        inj_result = '0;
        drive_req(1'b1, F_ADD, 16'h0001, 16'h0001, 1'b1, F_ADD, 16'h0001, 16'h0001);

        vt[0] = '{1'b1, 1'b0, F_ADD, 16'h0003, 16'h0004, F_ADD, 16'h0000, 16'h0000, 1'b0, 16'h0007};
        vt[1] = '{1'b0, 1'b1, F_ADD, 16'h0000, 16'h0000, F_SUB, 16'h0005, 16'h0007, 1'b1, 16'hFFFE};
        vt[2] = '{1'b1, 1'b1, F_AND, 16'hF0F0, 16'h3C3C, F_SUB, 16'h0009, 16'h0001, 1'b0, 16'h3030};
        vt[3] = '{1'b1, 1'b1, F_ADD, 16'h0002, 16'h0002, F_OR,  16'h00F0, 16'h0F00, 1'b1, 16'h0FF0};
        vt[4] = '{1'b0, 1'b1, F_ADD, 16'h0000, 16'h0000, F_XOR, 16'hFFFF, 16'h1234, 1'b1, 16'hEDCB};
        vt[5] = '{1'b1, 1'b1, F_ADD, 16'hFFFF, 16'h0001, F_OR,  16'h1111, 16'h2222, 1'b0, 16'h0000};
        vt[6] = '{1'b1, 1'b0, F_SUB, 16'h0000, 16'h0001, F_ADD, 16'h0000, 16'h0000, 1'b0, 16'hFFFF};
        vt[7] = '{1'b1, 1'b1, F_XOR, 16'h00FF, 16'h0F0F, F_ADD, 16'h8000, 16'h8000, 1'b1, 16'h0000};

        // Reset state, with both requesters valid while reset is held.
        tick();
        tick();
        check("rst ready0", 32'(req0_ready), 0);
        check("rst ready1", 32'(req1_ready), 0);
        check("rst busy", 32'(busy), 0);
        check("rst alu_en", 32'(alu_en), 0);
        check("rst alu_func", 32'(alu_func), 0);
        check("rst alu_a", 32'(alu_a), 0);
        check("rst alu_b", 32'(alu_b), 0);
        check("rst rsp_valid", 32'(rsp_valid), 0);
        check("rst rsp_id", 32'(rsp_id), 0);
        check("rst rsp_data", 32'(rsp_data), 0);
        check("rst rsp_err", 32'(rsp_err), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vt[i]);
        end

        // Contention straight out of reset: grants alternate 0,1,0,1.
        rst = 1'b1;
        drive_req(1'b1, F_ADD, 16'h0003, 16'h0004, 1'b1, F_SUB, 16'h0005, 16'h0007);
        tick();
        check("cont rst ready0", 32'(req0_ready), 0);
        check("cont rst ready1", 32'(req1_ready), 0);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            int w;
            logic exp_id;
            exp_id = logic'(k % 2);
            w = 0;
            while (!(req0_ready || req1_ready) && w < 20) begin
                tick();
                w++;
            end
            check($sformatf("cont%0d ready0", k), 32'(req0_ready), 32'(!exp_id));
            check($sformatf("cont%0d ready1", k), 32'(req1_ready), 32'(exp_id));
            sb.push_back('{id: exp_id, data: (exp_id ? 16'hFFFE : 16'h0007), err: 1'b0});
            tick();
            wait_rsp(10, cyc);
            compare_rsp($sformatf("cont%0d", k));
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure plus a stray done while the response is held.
        wait_idle("bp");
        rsp_ready = 1'b0;
        drive_req(1'b1, F_ADD, 16'h1111, 16'h2222, 1'b0, F_ADD, 16'h0000, 16'h0000);
        check("bp ready0", 32'(req0_ready), 1);
        sb.push_back('{id: 1'b0, data: 16'h3333, err: 1'b0});
        tick();
        req1_valid = 1'b1;   // both valid for the whole stall
        wait_rsp(10, cyc);
        check("bp latency", 32'(cyc), 2);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 1);
            check($sformatf("bp%0d rsp_data", k), 32'(rsp_data), 32'h3333);
            check($sformatf("bp%0d rsp_err", k), 32'(rsp_err), 0);
            check($sformatf("bp%0d ready0", k), 32'(req0_ready), 0);
            check($sformatf("bp%0d ready1", k), 32'(req1_ready), 0);
            done_inj   = (k == 1);
            inj_result = 16'hBEEF;
            tick();
        end
        done_inj = 1'b0;
        compare_rsp("bp");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        tick();
        check("bp rsp_valid after hs", 32'(rsp_valid), 0);
        check("bp busy after hs", 32'(busy), 0);

        // Stray done in IDLE changes nothing.
        done_inj = 1'b1;
        inj_result = 16'h5A5A;
        tick();
        done_inj = 1'b0;
        check("idle done busy", 32'(busy), 0);
        check("idle done rsp_valid", 32'(rsp_valid), 0);
        check("idle done rsp_data", 32'(rsp_data), 32'h3333);
        check("idle done rsp_err", 32'(rsp_err), 0);
        tick();
        check("idle done busy later", 32'(busy), 0);

        // Timeout with the ALU silent: TIMEOUT wait cycles, then err.
        alu_auto = 1'b0;
        drive_req(1'b0, F_ADD, 16'h0000, 16'h0000, 1'b1, F_ADD, 16'h0001, 16'h0001);
        check("to ready1", 32'(req1_ready), 1);
        sb.push_back('{id: 1'b1, data: 16'h0000, err: 1'b1});
        tick();
        req1_valid = 1'b0;
        wait_rsp(30, cyc);
        check("to latency", 32'(cyc), 32'(TO + 1));
        compare_rsp("to");
        tick();

        // Done arriving on the last counted wait cycle wins over timeout.
        wait_idle("to_last");
        drive_req(1'b1, F_SUB, 16'h0009, 16'h0002, 1'b0, F_ADD, 16'h0000, 16'h0000);
        check("to_last ready0", 32'(req0_ready), 1);
        sb.push_back('{id: 1'b0, data: 16'hABCD, err: 1'b0});
        tick();
        req0_valid = 1'b0;
        for (int k = 0; k < TO; k++) begin
            tick();
        end
        check("to_last no early rsp", 32'(rsp_valid), 0);
        done_inj = 1'b1;
        inj_result = 16'hABCD;
        tick();
        done_inj = 1'b0;
        compare_rsp("to_last");
        tick();

        // Reset pulse in WAIT; late done ignored; priority back to req0.
        // The previous grant went to req0, so without reset req1 would win.
        wait_idle("rstw");
        drive_req(1'b1, F_ADD, 16'h0002, 16'h0002, 1'b0, F_ADD, 16'h0000, 16'h0000);
        check("rstw ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        tick();  // WAIT
        check("rstw busy in wait", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done_inj = 1'b1;
        inj_result = 16'h7777;
        tick();
        done_inj = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rstw%0d rsp_valid", k), 32'(rsp_valid), 0);
            check($sformatf("rstw%0d busy", k), 32'(busy), 0);
            tick();
        end
        check("rstw rsp_data", 32'(rsp_data), 0);
        alu_auto = 1'b1;
        drive_req(1'b1, F_ADD, 16'h0002, 16'h0003, 1'b1, F_SUB, 16'h0008, 16'h0001);
        check("rstw prio ready0", 32'(req0_ready), 1);
        check("rstw prio ready1", 32'(req1_ready), 0);
        sb.push_back('{id: 1'b0, data: 16'h0005, err: 1'b0});
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(10, cyc);
        compare_rsp("rstw");
        tick();

        check("scoreboard drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
